afifo_wr_arbiter: RTL

- Round-robin scheduler that shares the single AFIFO write port (wclk = clk1) between NREQ producers in the clk1 domain, for example several doraemon-selection datapaths.
- Grants at most one beat per cycle and holds each granted producer for up to MAX_BURST consecutive beats.
- Registers the granted beat into a one-entry output stage that drives winc/wdata and retries while wfull is high.
- Sits between the producers and the AFIFO write side, replacing ad-hoc stall logic in each producer.

---
 rtl/afifo_wr_arbiter.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/afifo_wr_arbiter.sv
// afifo_wr_arbiter
// Round-robin scheduler for the single AFIFO write port (wclk = clk1).
// Each cycle it grants at most one of NREQ producers. A granted owner keeps
// the port for up to MAX_BURST consecutive beats before the grant rotates.
// The granted beat goes into a one-entry output stage. That stage drives
// winc/wdata and retries every cycle while wfull is high.
//
// Ports:
//   clk1      write-domain clock
//   rst_n     asynchronous active-low reset
//   clr       synchronous clear (drops staged beat, owner/burst to 0)
//   req       per-requester beat request, held with stable data until granted
//   req_data  packed beats, requester i at [i*DSIZE +: DSIZE]
//   gnt       one-hot combinational grant (beat accepted this cycle)
//   wfull     AFIFO full flag
//   winc      AFIFO write enable (registered)
//   wdata     AFIFO write data (registered)
//   owner     index of current/last owner (registered)
//   busy      staged beat pending (same as winc)
//
// Optional build macro AFIFO_ARB_STATS_EN adds two saturating 16-bit
// counters. stall_cnt counts cycles with winc && wfull. beat_cnt counts
// drained beats. clr clears both counters.
module afifo_wr_arbiter #(
    parameter  int DSIZE     = 8,
    parameter  int NREQ      = 4,
    parameter  int MAX_BURST = 4,
    localparam int OW        = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk1,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*DSIZE-1:0] req_data,
    output logic [NREQ-1:0]       gnt,
    input  logic                  wfull,
    output logic                  winc,
    output logic [DSIZE-1:0]      wdata,
    output logic [OW-1:0]         owner,
    output logic                  busy
`ifdef AFIFO_ARB_STATS_EN
    ,
    output logic [15:0]           stall_cnt,
    output logic [15:0]           beat_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SEND = 2'b01,
        HOLD = 2'b10
    } state_t;

    state_t            state, state_nxt;
    logic [3:0]        burst_cnt;
    logic              drain, accept, cont, found;
    logic [OW-1:0]     winner;
    logic [DSIZE-1:0]  slot [NREQ];
    int unsigned       idx;

    for (genvar g = 0; g < NREQ; g++) begin : g_slot
        assign slot[g] = req_data[g*DSIZE +: DSIZE];
    end

    assign winc   = (state != IDLE);
    assign busy   = winc;
    assign drain  = winc && !wfull;
    assign accept = (|req) && !clr && (!winc || drain);

    // Winner selection. The owner keeps the grant while it still requests and
    // its burst budget remains. Otherwise the scan starts at owner+1 and
    // wraps, so the owner is tried last. A lone owner that used up its budget
    // therefore wins again with a fresh burst.
    always_comb begin
        cont   = req[owner] && (burst_cnt < 4'(MAX_BURST));
        found  = cont;
        winner = owner;
        idx    = 0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = (32'(owner) + k) % 32'(NREQ);
            if (!found && req[OW'(idx)]) begin
                winner = OW'(idx);
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        gnt = '0;
        if (accept && rst_n)
            gnt[winner] = 1'b1;
    end

    always_comb begin
        state_nxt = state;
        if (clr)
            state_nxt = IDLE;
        else if (accept)
            state_nxt = SEND;
        else if (winc && wfull)
            state_nxt = HOLD;
        else
            state_nxt = IDLE;
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // cont is only true below MAX_BURST, so the increment cannot pass it.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            wdata     <= '0;
            owner     <= '0;
            burst_cnt <= '0;
        end else if (clr) begin
            owner     <= '0;
            burst_cnt <= '0;
        end else if (accept) begin
            wdata     <= slot[winner];
            owner     <= winner;
            burst_cnt <= cont ? burst_cnt + 4'd1 : 4'd1;
        end
    end

`ifdef AFIFO_ARB_STATS_EN
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            beat_cnt  <= '0;
        end else if (clr) begin
            stall_cnt <= '0;
            beat_cnt  <= '0;
        end else begin
            if (winc && wfull && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 16'd1;
            if (drain && (beat_cnt != '1))
                beat_cnt <= beat_cnt + 16'd1;
        end
    end
`endif

endmodule
